// File: rtl/cpu_pkg.sv
// cpu_pkg: arbiter state encoding and requester IDs shared by the memory arbiter
package cpu_pkg;
  typedef enum logic [1:0] {IDLE = 2'd0, GNT_I = 2'd1, GNT_D = 2'd2} arb_state_t;
  localparam logic REQ_I = 1'b0;
  localparam logic REQ_D = 1'b1;
endpackage

// File: rtl/MUX32_2_1.sv
// MUX32_2_1: two-input word multiplexer, b selected when sel is high
module MUX32_2_1 #(
  parameter int W = 32
) (
  input  logic [W-1:0] a,
  input  logic [W-1:0] b,
  input  logic         sel,
  output logic [W-1:0] y
);
  assign y = sel ? b : a;
endmodule

// File: rtl/mem_arbiter.sv
// mem_arbiter: round-robin sharing of one single-ported memory between fetch and data requesters with timeout
module mem_arbiter
  import cpu_pkg::*;
#(
  parameter int AW = 32,
  parameter int DW = 32,
  parameter int WAIT_MAX = 16
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          i_req,
  input  logic [AW-1:0] i_addr,
  output logic          i_ack,
  output logic [DW-1:0] i_rdata,
  input  logic          d_req,
  input  logic          d_we,
  input  logic [AW-1:0] d_addr,
  input  logic [DW-1:0] d_wdata,
  output logic          d_ack,
  output logic [DW-1:0] d_rdata,
  output logic          bus_err,
  output logic          mem_en,
  output logic          mem_we,
  output logic [AW-1:0] mem_addr,
  output logic [DW-1:0] mem_wdata,
  input  logic [DW-1:0] mem_rdata,
  input  logic          mem_ready
);
  localparam logic [7:0] WAIT_LAST = 8'(WAIT_MAX - 1);
  arb_state_t state_q, state_d;
  logic last_q, last_d;
  logic [7:0] wait_q, wait_d;
  logic i_ack_q, i_ack_d, d_ack_q, d_ack_d, err_q, err_d, en_q, en_d, we_q, we_d;
  logic [AW-1:0] addr_q, addr_d, addr_mux;
  logic [DW-1:0] wdata_q, wdata_d, wdata_mux, i_rdata_q, i_rdata_d, d_rdata_q, d_rdata_d;
  logic eff_i, eff_d, gnt_i, gnt_d, gnt, busy, is_d, done, tmo, fin;
  assign eff_i = i_req & ~i_ack_q;
  assign eff_d = d_req & ~d_ack_q;
  assign gnt_d = state_q == IDLE & eff_d & (~eff_i | last_q == REQ_I);
  assign gnt_i = state_q == IDLE & eff_i & ~gnt_d;
  assign gnt = gnt_i | gnt_d;
  assign busy = state_q != IDLE;
  assign is_d = state_q == GNT_D;
  assign done = busy & mem_ready;
  assign tmo = busy & ~mem_ready & wait_q == WAIT_LAST;
  assign fin = done | tmo;
  MUX32_2_1 #(.W(AW)) u_addr_mux (.a(i_addr), .b(d_addr), .sel(gnt_d), .y(addr_mux));
  MUX32_2_1 #(.W(DW)) u_wdata_mux (.a('0), .b(d_wdata), .sel(gnt_d), .y(wdata_mux));
  always_comb begin
    state_d = gnt_d ? GNT_D : gnt_i ? GNT_I : fin ? IDLE : state_q;
    last_d = fin ? (is_d ? REQ_D : REQ_I) : last_q;
    wait_d = gnt ? '0 : busy & ~fin ? wait_q + 8'd1 : wait_q;
    i_ack_d = fin & ~is_d;
    d_ack_d = fin & is_d;
    err_d = tmo;
    en_d = gnt | (busy & ~fin);
    we_d = gnt_d ? d_we : busy & ~fin & we_q;
    addr_d = gnt ? addr_mux : addr_q;
    wdata_d = gnt ? wdata_mux : wdata_q;
    i_rdata_d = fin & ~is_d ? (done ? mem_rdata : '0) : i_rdata_q;
    d_rdata_d = fin & is_d ? (done & ~we_q ? mem_rdata : '0) : d_rdata_q;
  end
  always_ff @(posedge clk)
    if (rst) begin
      state_q <= IDLE;
      last_q <= REQ_I;
      wait_q <= '0;
      i_ack_q <= 1'b0;
      d_ack_q <= 1'b0;
      err_q <= 1'b0;
      en_q <= 1'b0;
      we_q <= 1'b0;
      addr_q <= '0;
      wdata_q <= '0;
      i_rdata_q <= '0;
      d_rdata_q <= '0;
    end else begin
      state_q <= state_d;
      last_q <= last_d;
      wait_q <= wait_d;
      i_ack_q <= i_ack_d;
      d_ack_q <= d_ack_d;
      err_q <= err_d;
      en_q <= en_d;
      we_q <= we_d;
      addr_q <= addr_d;
      wdata_q <= wdata_d;
      i_rdata_q <= i_rdata_d;
      d_rdata_q <= d_rdata_d;
    end
  assign i_ack = i_ack_q;
  assign d_ack = d_ack_q;
  assign bus_err = err_q;
  assign mem_en = en_q;
  assign mem_we = we_q;
  assign mem_addr = addr_q;
  assign mem_wdata = wdata_q;
  assign i_rdata = i_rdata_q;
  assign d_rdata = d_rdata_q;
endmodule

// File: tb/tb_mem_arbiter.sv
// tb_mem_arbiter: directed scenarios against a transaction-level arbiter model with per-cycle checks
module tb_mem_arbiter;
  localparam int WM = 4;
  localparam int MN = 0;
  localparam int MI = 1;
  localparam int MD = 2;
  logic clk, rst, i_req, i_ack, d_req, d_we, d_ack, bus_err, mem_en, mem_we, mem_ready;
  logic [31:0] i_addr, i_rdata, d_addr, d_wdata, d_rdata, mem_addr, mem_wdata, mem_rdata;
  int n_tests = 0;
  int n_fail = 0;
  mem_arbiter #(.AW(32), .DW(32), .WAIT_MAX(WM)) dut (
    .clk(clk), .rst(rst),
    .i_req(i_req), .i_addr(i_addr), .i_ack(i_ack), .i_rdata(i_rdata),
    .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata), .d_ack(d_ack), .d_rdata(d_rdata),
    .bus_err(bus_err), .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_rdata(mem_rdata), .mem_ready(mem_ready)
  );
  initial clk = 1'b0;
  always #5 clk = ~clk;
  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask
  task automatic cyc();
    @(posedge clk);
    #1;
  endtask
  int owner, waited, last;
  bit armed, ci, cd, ok;
  logic m_iack, m_dack, m_err, m_en, m_we;
  logic [31:0] m_addr, m_wdata, m_ird, m_drd;
  always @(posedge clk) begin
    ci = i_req && !m_iack;
    cd = d_req && !m_dack;
    m_iack = 1'b0;
    m_dack = 1'b0;
    m_err = 1'b0;
    if (rst) begin
      armed = 1'b1;
      owner = MN;
      last = MI;
      waited = 0;
      m_en = 1'b0;
      m_we = 1'b0;
      m_addr = 0;
      m_wdata = 0;
      m_ird = 0;
      m_drd = 0;
    end else if (owner != MN) begin
      if (mem_ready || waited == WM - 1) begin
        ok = mem_ready;
        if (owner == MI) begin
          m_iack = 1'b1;
          m_ird = ok ? mem_rdata : 0;
        end else begin
          m_dack = 1'b1;
          m_drd = (ok && !m_we) ? mem_rdata : 0;
        end
        m_err = !ok;
        last = owner;
        owner = MN;
        m_en = 1'b0;
        m_we = 1'b0;
      end else waited++;
    end else if (ci || cd) begin
      owner = (ci && cd) ? (last == MI ? MD : MI) : (cd ? MD : MI);
      waited = 0;
      m_en = 1'b1;
      m_we = owner == MD && d_we;
      m_addr = owner == MD ? d_addr : i_addr;
      m_wdata = owner == MD ? d_wdata : 0;
    end
  end
  always @(negedge clk)
    if (armed) begin
      chk("i_ack", i_ack, m_iack);
      chk("d_ack", d_ack, m_dack);
      chk("mem_en", mem_en, m_en);
      chk("mem_we", mem_we, m_we);
      if (m_iack || m_dack) chk("bus_err", bus_err, m_err);
      if (m_iack) chk("i_rdata", i_rdata, m_ird);
      if (m_dack) chk("d_rdata", d_rdata, m_drd);
      if (m_en) chk("mem_addr", mem_addr, m_addr);
      if (m_en) chk("mem_wdata", mem_wdata, m_wdata);
      chk("both_acks", i_ack & d_ack, 0);
      chk("en_with_ack", mem_en & (i_ack | d_ack), 0);
    end
  int t_i, t_d, t, n_we, n_ack;
  initial begin
    {i_req, d_req, d_we, mem_ready} = 4'b0;
    i_addr = 0;
    d_addr = 0;
    d_wdata = 0;
    mem_rdata = 0;
    rst = 1'b1;
    cyc();
    cyc();
    chk("rst_mem_en", mem_en, 0);
    chk("rst_mem_addr", mem_addr, 0);
    chk("rst_i_ack", i_ack, 0);
    chk("rst_d_rdata", d_rdata, 0);
    rst = 1'b0;
    i_req = 1'b1;
    i_addr = 32'h100;
    mem_ready = 1'b1;
    mem_rdata = 32'h1234;
    cyc();
    chk("s1_mem_en", mem_en, 1);
    chk("s1_mem_addr", mem_addr, 32'h100);
    cyc();
    chk("s1_i_ack", i_ack, 1);
    chk("s1_i_rdata", i_rdata, 32'h1234);
    chk("s1_bus_err", bus_err, 0);
    i_req = 1'b0;
    cyc();
    chk("s1_i_ack_pulse", i_ack, 0);
    chk("s1_mem_en_off", mem_en, 0);
    rst = 1'b1;
    cyc();
    rst = 1'b0;
    i_req = 1'b1;
    d_req = 1'b1;
    d_we = 1'b0;
    i_addr = 32'h300;
    d_addr = 32'h200;
    mem_rdata = 32'h55;
    mem_ready = 1'b1;
    t_i = -1;
    t_d = -1;
    for (int c = 1; c <= 20; c++) begin
      cyc();
      mem_ready = (c != 3);
      if (d_ack) begin
        t_d = c;
        d_req = 1'b0;
      end
      if (i_ack) begin
        t_i = c;
        i_req = 1'b0;
      end
    end
    chk("s2_d_ack_cycle", t_d, 2);
    chk("s2_i_ack_cycle", t_i, 5);
    chk("s2_ack_gap", t_i - t_d, 3);
    d_req = 1'b1;
    d_we = 1'b1;
    d_addr = 32'h40;
    d_wdata = 32'hDEADBEEF;
    mem_rdata = 32'h9999;
    mem_ready = 1'b0;
    n_we = 0;
    n_ack = 0;
    for (int c = 1; c <= 10; c++) begin
      cyc();
      mem_ready = (c == 4);
      if (mem_en && mem_we && mem_wdata == 32'hDEADBEEF) n_we++;
      if (d_ack) begin
        n_ack++;
        chk("s3_d_rdata", d_rdata, 0);
        d_req = 1'b0;
        d_we = 1'b0;
      end
    end
    chk("s3_we_cycles", n_we, 4);
    chk("s3_ack_count", n_ack, 1);
    i_req = 1'b1;
    i_addr = 32'h500;
    mem_ready = 1'b0;
    mem_rdata = 32'h7777;
    t = -1;
    for (int c = 1; c <= 10; c++) begin
      cyc();
      if (i_ack) begin
        t = c;
        chk("s4a_bus_err", bus_err, 1);
        chk("s4a_i_rdata", i_rdata, 0);
        i_req = 1'b0;
      end
    end
    chk("s4a_ack_cycle", t, 5);
    d_req = 1'b1;
    d_we = 1'b0;
    d_addr = 32'h80;
    mem_rdata = 32'hABCD;
    t = -1;
    for (int c = 1; c <= 10; c++) begin
      cyc();
      mem_ready = (c == 4);
      if (d_ack) begin
        t = c;
        chk("s4b_bus_err", bus_err, 0);
        chk("s4b_d_rdata", d_rdata, 32'hABCD);
        d_req = 1'b0;
      end
    end
    chk("s4b_ack_cycle", t, 5);
    d_req = 1'b1;
    d_addr = 32'hC0;
    mem_ready = 1'b0;
    cyc();
    cyc();
    rst = 1'b1;
    cyc();
    rst = 1'b0;
    d_req = 1'b0;
    chk("s5_mem_en", mem_en, 0);
    chk("s5_mem_we", mem_we, 0);
    chk("s5_mem_addr", mem_addr, 0);
    chk("s5_mem_wdata", mem_wdata, 0);
    chk("s5_i_ack", i_ack, 0);
    chk("s5_d_ack", d_ack, 0);
    chk("s5_bus_err", bus_err, 0);
    chk("s5_i_rdata", i_rdata, 0);
    chk("s5_d_rdata", d_rdata, 0);
    n_ack = 0;
    for (int c = 1; c <= 5; c++) begin
      cyc();
      mem_ready = 1'b1;
      if (d_ack) n_ack++;
    end
    chk("s5_no_d_ack", n_ack, 0);
    i_req = 1'b1;
    d_req = 1'b1;
    i_addr = 32'h111;
    d_addr = 32'h222;
    mem_rdata = 32'h3;
    cyc();
    chk("s5_first_gnt_en", mem_en, 1);
    chk("s5_first_gnt_addr", mem_addr, 32'h222);
    for (int c = 1; c <= 10; c++) begin
      cyc();
      if (d_ack) d_req = 1'b0;
      if (i_ack) i_req = 1'b0;
    end
    chk("s5_reqs_served", {i_req, d_req}, 0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule

// File: doc/mem_arbiter.md
MEM_ARBITER -- requirements
Module: mem_arbiter

Interface
REQ-001 SHALL have parameter AW, default 32, address width.
REQ-002 SHALL have parameter DW, default 32, data width.
REQ-003 SHALL have parameter WAIT_MAX, default 16, max wait cycles per access before timeout (legal range 1..255).
REQ-004 One clock; reset is synchronous and active-high.
REQ-005 SHALL have ports in this order:
- clk  in  1  clock, rising edge
- rst  in  1  synchronous active-high reset
- i_req  in  1  instruction-fetch request
- i_addr  in  AW  fetch address
- i_ack  out  1  fetch done, one-cycle pulse
- i_rdata  out  DW  fetch data, valid with i_ack
- d_req  in  1  data request
- d_we  in  1  data write enable
- d_addr  in  AW  data address
- d_wdata  in  DW  write data
- d_ack  out  1  data done, one-cycle pulse
- d_rdata  out  DW  load data, valid with d_ack
- bus_err  out  1  timeout flag, valid with i_ack/d_ack
- mem_en  out  1  memory access strobe
- mem_we  out  1  memory write
- mem_addr  out  AW  memory address
- mem_wdata  out  DW  memory write data
- mem_rdata  in  DW  memory read data
- mem_ready  in  1  memory completes the current access this cycle

Function
REQ-006 SHALL share one single-ported memory between the fetch (I) and data (D) requesters.
REQ-007 SHALL implement the states IDLE, GNT_I and GNT_D.
REQ-008 SHALL keep a last_served bit, reset value I.
REQ-009 In IDLE with exactly one request pending, SHALL grant that requester.
- With both pending, SHALL grant the one not equal to last_served (round-robin), so D wins first after reset.
REQ-010 On a grant, SHALL in the same edge:
- register mem_addr and mem_wdata from the granted requester;
- set mem_we = d_we for a D grant, 0 for an I grant;
- set mem_en=1 from the next cycle.
REQ-011 Requesters SHALL hold req, addr, we and wdata stable until their ack; the arbiter SHALL NOT re-sample them during a grant.
REQ-012 In GNT_x with mem_ready=1, SHALL on the next edge:
- capture mem_rdata into x_rdata;
- pulse x_ack for one cycle with bus_err=0;
- update last_served=x;
- return to IDLE with mem_en=0 and mem_we=0.
REQ-013 A D write SHALL return d_rdata=0.
REQ-014 Minimum latency SHALL be: req at cycle 0, mem_en at cycle 1, ack at cycle 2 if mem_ready is high in cycle 1.
REQ-015 In the ack cycle, the arbiter SHALL ignore the acked requester's req, so that requester cannot be double-granted; the other requester's req SHALL be eligible that cycle.
REQ-016 SHALL keep a wait counter:
- cleared on grant;
- incremented each GNT cycle with mem_ready=0;
- when it reaches WAIT_MAX-1 with mem_ready=0, SHALL ack with bus_err=1 and x_rdata=0, then return to IDLE.
REQ-017 If mem_ready=1 in the timeout cycle, ready SHALL win and bus_err SHALL be 0.
REQ-018 At most one of mem_en-owner, i_ack and d_ack SHALL be active per cycle; i_ack and d_ack SHALL never both be 1.

Reset
REQ-019 rst SHALL force, on the next edge:
- state=IDLE, last_served=I, wait counter=0;
- i_ack, d_ack, bus_err, mem_en, mem_we = 0;
- mem_addr, mem_wdata, i_rdata, d_rdata = 0.
REQ-020 Reset mid-access SHALL abort the access with no ack issued; rst SHALL take priority over all other inputs.

Structure
REQ-021 The state encoding (IDLE=2'd0, GNT_I=2'd1, GNT_D=2'd2) and the requester ID constants SHALL live in the shared package cpu_pkg.
REQ-022 The address and write-data select SHALL instantiate the existing MUX32_2_1 (sel=grant is D); no other sub-module is used.

Verification
REQ-023 The bench SHALL cover these directed scenarios:
- Reset, then i_req=1, i_addr=0x100, mem_ready=1 always, mem_rdata=0x1234 -> mem_en cycle 1 with mem_addr=0x100, i_ack cycle 2 with i_rdata=0x1234 and bus_err=0.
- i_req and d_req both raised at cycle 0 after reset -> D served first, I granted in D's ack cycle, i_ack 3 cycles after d_ack.
- d_req, d_we=1, d_addr=0x40, d_wdata=0xDEADBEEF, mem_ready after 3 wait cycles -> mem_we=1 and mem_wdata=0xDEADBEEF held for 4 cycles, d_ack once with d_rdata=0.
- WAIT_MAX=4, mem_ready held 0 -> ack on cycle 5 after grant with bus_err=1; a second variant with mem_ready=1 in the 4th GNT cycle -> bus_err=0.
- rst asserted during the 2nd GNT_D cycle -> no d_ack ever, all outputs 0 next cycle, next contention granted to D.
